// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: shared state encoding, index-width helper and default sizes for the shared register arbiter
package shared_reg_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit scanning upward from last+1 with wrap-around
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter granting one requester at a time write access to a shared register
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   syncReset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       Q,
  output logic                   q_valid,
  output logic                   busy
);
  localparam int IW = idx_w(N_REQ);
  state_t        state, next_state;
  logic [IW-1:0] owner, last, pick_idx;
  logic          pick_found;
  logic          own_req;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );
  assign own_req = req[owner];
  assign busy    = state != ST_IDLE;
  always_comb begin
    next_state = ST_IDLE;
    next_state = state == ST_IDLE  ? (pick_found ? ST_WRITE : ST_IDLE) :
                 state == ST_WRITE ? (own_req ? ST_RELEASE : ST_IDLE) :
                 (state == ST_RELEASE && own_req) ? ST_RELEASE : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (syncReset) state <= ST_IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clk) begin
    if (syncReset) begin
      gnt     <= '0;
      ack     <= '0;
      Q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      last    <= IW'(N_REQ - 1);
    end else begin
      ack <= '0;
      if (state == ST_IDLE && pick_found) begin
        gnt   <= N_REQ'(1) << pick_idx;
        owner <= pick_idx;
      end else if (state == ST_WRITE && own_req) begin
        Q       <= data[owner*WIDTH +: WIDTH];
        q_valid <= 1'b1;
        ack     <= gnt;
        last    <= owner;
      end else if (state != ST_IDLE && !own_req) begin
        gnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
  logic        clk = 1'b0;
  logic        syncReset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt, ack;
  logic [7:0]  Q;
  logic        q_valid, busy;
  int          n_chk = 0;
  int          n_fail = 0;
  int          w;
  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .syncReset (syncReset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .ack       (ack),
    .Q         (Q),
    .q_valid   (q_valid),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    syncReset = 1'b1;
    req = 4'b0000;
    data = 32'h0;
    tick();
    tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_q", Q, 8'h00);
    chk("rst_qv", q_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    syncReset = 1'b0;
    req = 4'b0001;
    data[7:0] = 8'hA5;
    tick();
    chk("single_gnt", gnt, 4'b0001);
    chk("single_busy", busy, 1'b1);
    chk("single_ack_early", ack, 4'b0000);
    chk("single_q_early", Q, 8'h00);
    tick();
    chk("single_q", Q, 8'hA5);
    chk("single_ack", ack, 4'b0001);
    chk("single_qv", q_valid, 1'b1);
    tick();
    chk("single_ack_low", ack, 4'b0000);
    chk("single_gnt_hold", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    chk("single_rel_gnt", gnt, 4'b0000);
    chk("single_rel_busy", busy, 1'b0);
    syncReset = 1'b1;
    tick();
    syncReset = 1'b0;
    req = 4'b1111;
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 7; i++) begin
      w = i % 4;
      tick();
      chk("rr_gnt", gnt, 4'b0001 << w);
      tick();
      chk("rr_q", Q, 8'h10 + w);
      chk("rr_ack", ack, 4'b0001 << w);
      req[w] = 1'b0;
      tick();
      chk("rr_gap", gnt, 4'b0000);
      req = (i == 6) ? 4'b0101 : 4'b1111;
    end
    tick();
    chk("wrap_gnt0", gnt, 4'b0001);
    tick();
    chk("wrap_q0", Q, 8'h10);
    chk("wrap_ack0", ack, 4'b0001);
    req = 4'b0100;
    tick();
    chk("wrap_gap", gnt, 4'b0000);
    req = 4'b0101;
    tick();
    chk("wrap_gnt2", gnt, 4'b0100);
    tick();
    chk("wrap_q2", Q, 8'h12);
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    chk("pre_gnt3", gnt, 4'b1000);
    tick();
    chk("pre_q3", Q, 8'h13);
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    chk("wd_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    chk("wd_gnt0", gnt, 4'b0000);
    chk("wd_ack", ack, 4'b0000);
    chk("wd_q", Q, 8'h13);
    chk("wd_busy", busy, 1'b0);
    req = 4'b0110;
    tick();
    chk("wd_last_kept", gnt, 4'b0010);
    data[15:8] = 8'hFF;
    syncReset = 1'b1;
    tick();
    chk("mid_rst_q", Q, 8'h00);
    chk("mid_rst_qv", q_valid, 1'b0);
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_ack", ack, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    syncReset = 1'b0;
    req = 4'b0010;
    tick();
    chk("post_rst_gnt", gnt, 4'b0010);
    tick();
    chk("post_rst_q", Q, 8'hFF);
    chk("post_rst_ack", ack, 4'b0010);
    req = 4'b0000;
    tick();
    chk("post_rst_rel", gnt, 4'b0000);
    req = 4'b1000;
    tick();
    chk("hold_gnt", gnt, 4'b1000);
    tick();
    chk("hold_q", Q, 8'h13);
    chk("hold_ack", ack, 4'b1000);
    for (int i = 0; i < 10; i++) begin
      req[0] = ~req[0];
      data[31:24] = 8'h40 + 8'(i);
      tick();
      chk("hold_ack_low", ack, 4'b0000);
      chk("hold_gnt_stay", gnt, 4'b1000);
      chk("hold_q_stay", Q, 8'h13);
    end
    req = 4'b0000;
    tick();
    chk("hold_rel_gnt", gnt, 4'b0000);
    chk("hold_rel_busy", busy, 1'b0);
    chk("hold_qv_sticky", q_valid, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
